stream_demux_ctrl: RTL
======================

Name: stream_demux_ctrl

Overview:
- Sequenced 1-to-N demultiplexer controller with valid/ready handshakes on every port.
- Accepts a single input stream and routes each word to one of N_OUT output channels.
- Destination is either steered by the sender (in_dest) or chosen round-robin by the block.
- Sits between a shared producer and N consumer channels; one registered output stage gives full throughput with no combinational data path from input to output.

Parameters:
- N_OUT, 4, number of output channels (2..16).
- DATA_W, 8, data word width.
- SEL_W, 2, destination index width; must equal clog2(N_OUT), minimum 1.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = steered by in_dest, 1 = round-robin; sampled only on input acceptance.
- in_data  in  DATA_W  input word.
- in_dest  in  SEL_W  requested channel; ignored when mode=1.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept this cycle.
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  N_OUT  one-hot or zero; bit k means channel k holds a word.
- out_ready  in  N_OUT  per-channel consumer ready.
- dest_err  out  1  one-cycle pulse: steered word dropped because in_dest >= N_OUT.
- xfer_cnt  out  CNT_W  count of words delivered to outputs.

Behaviour:
- Reset (rst=1 at a clk edge), taking priority over all else:
  - State goes to EMPTY.
  - out_valid=0, out_data=0, rr_ptr=0, cur_dest=0, dest_err=0, xfer_cnt=0.
  - A word held mid-transfer is discarded.
  - in_ready reads 0 while rst is high.
- States:
  - EMPTY: output register free.
  - FULL: output register holds a word for cur_dest.
- in_ready (combinational) = !rst && (state==EMPTY || out_ready[cur_dest]).
- Accept = in_valid && in_ready.
- Deliver = state==FULL && out_ready[cur_dest].
- Destination on accept:
  - mode=1: dest = rr_ptr, then rr_ptr = rr_ptr+1, wrapping N_OUT-1 -> 0.
  - mode=0: dest = in_dest; rr_ptr is unchanged.
- Invalid destination (mode=0, in_dest >= N_OUT; possible only when N_OUT is not a power of 2):
  - The word is accepted and discarded.
  - dest_err pulses high for the next cycle.
  - Register contents are unchanged; if a word was also delivered that cycle, state goes to EMPTY.
- Transitions:
  - EMPTY + valid accept -> FULL, with out_data slice[dest] = in_data, cur_dest = dest, out_valid = 1<<dest.
  - FULL + Deliver + valid accept -> FULL with the new word (back-to-back, 1 word/cycle throughput).
  - FULL + Deliver + no accept -> EMPTY, out_valid = 0.
  - FULL + no Deliver -> hold; out_data and out_valid stay stable.
- Latency: exactly 1 cycle from accept to out_valid.
- Only the slice for cur_dest is meaningful; other slices hold their last written value.
- xfer_cnt increments by 1 on each Deliver and wraps at 2^CNT_W.
- out_ready bits other than cur_dest are ignored.
- A mode change while FULL does not affect the held word.

Decomposition:
- Shared header stream_demux_defs.vh holds:
  - state encodings ST_EMPTY=1'b0, ST_FULL=1'b1;
  - mode constants MODE_STEER=0, MODE_RR=1.
- One natural sub-module: rr_pointer (N_OUT, SEL_W; inputs clk, rst, advance; output ptr; wraps at N_OUT-1).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0000, xfer_cnt=0. Release -> in_ready=1.
- Steered: mode=0, send 0xA5 with dest 2, all out_ready=1 -> next cycle out_valid=0100 and slice2=0xA5. Following cycle out_valid=0000 and xfer_cnt=1.
- Round-robin throughput: mode=1, send 0x10..0x15 on consecutive cycles with all ready -> out_valid sequence 0001,0010,0100,1000,0001,0010. in_ready stays 1 throughout; xfer_cnt=6.
- Backpressure: mode=0, word 0x3C to dest 1 with out_ready[1]=0 for 3 cycles -> out_valid=0010 held, data stable, in_ready=0. Raise ready with the next word 0x3D (dest 3) valid -> same edge loads the new word and out_valid=1000.
- Invalid dest: N_OUT=3 build, mode=0, in_dest=3 -> word accepted and dest_err pulses 1 cycle. out_valid stays 000; xfer_cnt unchanged.
- Reset mid-transfer: FULL on dest 0 with out_ready=0, assert rst -> out_valid=0000 and rr_ptr=0 the next cycle. The held word is never delivered.

Source files
------------

// File: rtl/stream_demux_ctrl_pkg.sv
// Shared types and constants for the stream demultiplexer controller.
// The output stage has two states; mode selects how each word's destination is chosen.
package stream_demux_ctrl_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic MODE_STEER = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_demux_ctrl_if.sv
// Handshake bundle between one producer, the demux, and N_OUT consumer channels.
// A word moves on a port only in a cycle where both its valid and its ready are high.
interface stream_demux_ctrl_if #(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic                    mode;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_dest;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic                    dest_err;
    logic [CNT_W-1:0]        xfer_cnt;

    modport slave (
        input  mode, in_data, in_dest, in_valid, out_ready,
        output in_ready, out_data, out_valid, dest_err, xfer_cnt
    );

    modport master (
        output mode, in_data, in_dest, in_valid, out_ready,
        input  in_ready, out_data, out_valid, dest_err, xfer_cnt
    );
endinterface

// File: rtl/stream_demux_ctrl_rr_pointer.sv
// Round-robin channel pointer: advances one step per request and wraps
// from N_OUT-1 back to 0, so non-power-of-2 channel counts never see an unused index.
module stream_demux_ctrl_rr_pointer #(
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    output logic [SEL_W-1:0] o_ptr
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/stream_demux_ctrl.sv
// 1-to-N_OUT stream demultiplexer with a single registered output stage.
// Destination comes from in_dest (steered) or from the round-robin pointer.
module stream_demux_ctrl
    import stream_demux_ctrl_pkg::*;
#(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_demux_ctrl_if.slave      bus,
    output state_t                  o_dbg_state,
    output logic [SEL_W-1:0]        o_dbg_rr_ptr
);
    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

    state_t                  r_state;
    logic [SEL_W-1:0]        r_cur_dest;
    logic [N_OUT*DATA_W-1:0] r_out_data;
    logic [N_OUT-1:0]        r_out_valid;
    logic                    r_dest_err;
    logic [CNT_W-1:0]        r_xfer_cnt;

    logic [SEL_W-1:0]        w_rr_ptr;
    logic [SEL_W-1:0]        w_dest;
    logic                    w_dest_ok;
    logic                    w_accept;
    logic                    w_deliver;

    // The input may take a word whenever the output register is free or is being drained this cycle.
    assign bus.in_ready = !rst && (r_state == ST_EMPTY || bus.out_ready[r_cur_dest]);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_deliver    = (r_state == ST_FULL) && bus.out_ready[r_cur_dest];
    assign w_dest       = (bus.mode == MODE_RR) ? w_rr_ptr : bus.in_dest;
    assign w_dest_ok    = {1'b0, w_dest} < N_OUT_W;

    stream_demux_ctrl_rr_pointer #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_rr_pointer (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_accept && bus.mode == MODE_RR),
        .o_ptr     (w_rr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_cur_dest  <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_dest_err  <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            r_dest_err <= w_accept && !w_dest_ok;
            if (w_deliver) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            // A dropped out-of-range word leaves the register alone but still frees it if drained.
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept && w_dest_ok) begin
                        r_state                             <= ST_FULL;
                        r_cur_dest                          <= w_dest;
                        r_out_data[w_dest*DATA_W +: DATA_W] <= bus.in_data;
                        r_out_valid                         <= {{(N_OUT-1){1'b0}}, 1'b1} << w_dest;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_dest_ok) begin
                        r_cur_dest                          <= w_dest;
                        r_out_data[w_dest*DATA_W +: DATA_W] <= bus.in_data;
                        r_out_valid                         <= {{(N_OUT-1){1'b0}}, 1'b1} << w_dest;
                    end else if (w_deliver) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= '0;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.dest_err  = r_dest_err;
    assign bus.xfer_cnt  = r_xfer_cnt;
    assign o_dbg_state   = r_state;
    assign o_dbg_rr_ptr  = w_rr_ptr;
endmodule
